plru_replacement_ctrl: RTL
==========================

Name: plru_replacement_ctrl

Overview:
- Sequential owner of tree-PLRU replacement state for a set-associative cache.
- Stores one (NUM_WAYS-1)-bit tree per set.
- Accepts access notifications ("touch") from the hit path and answers victim requests from the miss/fill path through a valid/ready handshake.
- Sits between the cache tag pipeline (producer of touches) and the refill controller (consumer of victims).
- Runs an init/flush sweep that clears all trees.

Parameters:
- NUM_WAYS, 4, associativity; power of two, >=2.
- NUM_SETS, 64, number of sets; power of two, >=2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- touch_valid  in  1  access notification; always accepted in RUN, dropped otherwise.
- touch_set  in  $clog2(NUM_SETS)  set index of the access.
- touch_way  in  $clog2(NUM_WAYS)  way accessed.
- vic_req_valid  in  1  victim request.
- vic_req_ready  out  1  request accepted when valid&&ready.
- vic_req_set  in  $clog2(NUM_SETS)  set to choose a victim from.
- vic_req_alloc  in  1  when set, treat the chosen victim as accessed at acceptance.
- vic_rsp_valid  out  1  victim response valid.
- vic_rsp_ready  in  1  consumer accepts response.
- vic_rsp_set  out  $clog2(NUM_SETS)  echoed set.
- vic_rsp_way  out  $clog2(NUM_WAYS)  chosen victim way.
- flush_req  in  1  single-cycle pulse: clear all trees.
- busy  out  1  high in INIT or FLUSH.

Behaviour:
- Tree encoding:
  - Nodes are heap-indexed 1..NUM_WAYS-1; node r has children 2r (bit=0) and 2r+1 (bit=1).
  - Victim walk: start at r=1, repeat L=$clog2(NUM_WAYS) times r=2r+tree[r]; result is way=r-NUM_WAYS.
  - Update on access of way w: at level k (0=root) the path node gets bit = ~w[L-1-k], so the walk points away from w. Bits are set, never toggled; off-path nodes are unchanged.
- State storage is plain flops or RAM with no reset. Only the FSM and output registers are reset.
- FSM states: INIT, RUN, FLUSH.
  - Async reset -> INIT, sweep pointer=0, vic_rsp_valid=0, vic_rsp_set=0, vic_rsp_way=0, busy=1, vic_req_ready=0.
  - INIT/FLUSH write all-zero tree to set[ptr], one set per cycle, ptr++. At ptr==NUM_SETS-1 the next state is RUN, so the sweep takes NUM_SETS cycles.
  - RUN + flush_req -> FLUSH next cycle, ptr=0.
  - flush_req is ignored in INIT and FLUSH.
  - Reset mid-sweep restarts INIT from set 0.
- vic_req_ready = (state==RUN) && !flush_req && (!vic_rsp_valid || vic_rsp_ready).
- Victim latency: 1 cycle.
  - The victim is computed combinationally at acceptance from the array contents of that cycle, before any same-cycle write.
  - It is registered into vic_rsp_* with vic_rsp_valid=1 the next cycle.
  - The response holds stable until vic_rsp_valid&&vic_rsp_ready.
  - Back-to-back: accept a new request in the cycle the old response is consumed.
- Touch writes take effect at the next clock edge. A victim request to the same set in the following cycle sees the updated tree; no read-before-write hazard is visible.
- Same cycle, same set, touch and accepted alloc request:
  - The victim is computed from the pre-update tree.
  - The touch update is applied first, then the alloc update; alloc wins on shared nodes. Both land in one write.
- Same cycle, different sets: both writes are performed. Two write ports or an equivalent flop array are required.
- Touch in INIT/FLUSH or in the cycle flush_req is seen: dropped.
- A pending response in RUN->FLUSH is retained and still delivered.
- Out-of-range inputs are impossible: all widths are exact.

Decomposition:
- Package plru_pkg holds:
  - localparams for L and index widths;
  - typedef fsm_state_e {INIT, RUN, FLUSH};
  - automatic functions plru_victim(tree) and plru_touch(tree, way), parameterised via the package's class-free width-generic pattern.
- Sub-module plru_tree_logic: combinational victim+update for one tree, instantiated twice (touch path, alloc path).
- The controller holds the FSM, storage and response register.

Test Plan:
- Reset, then hold vic_req_valid → busy=1 and vic_req_ready=0 for exactly 64 cycles; first response for set 5 is way 0.
- After init, touch set 3 way 0, then request set 3 → tree=3'b011 (node1=1, node2=1), vic_rsp_way=2. Then touch way 2 and request again → vic_rsp_way=1.
- Request set 7 with alloc=1 three times back-to-back, rsp_ready=1 → ways 0, 2, 1; the fourth request returns 3.
- Same cycle: touch set 9 way 1 and alloc request set 9 → response way 0; final tree node1=1, node2=1 (alloc wins); the next request returns way 2.
- Hold vic_rsp_ready=0 for 4 cycles → response stable, vic_req_ready=0; release → handshake completes and a new request is accepted that cycle.
- Touch set 2 way 0, then flush_req with a response pending → pending response delivered, busy=1 for 64 cycles, touches dropped; afterwards set 2 returns way 0.

Source files
------------

// File: rtl/plru_pkg.sv
// plru_pkg -- shared definitions for the tree-PLRU replacement controller.
//
// Contents:
//   * Default geometry (ways, sets) and the derived level/index widths.
//   * fsm_state_e: controller states INIT / RUN / FLUSH.
//   * plru_victim / plru_touch: width-generic tree helpers. Trees are
//     passed zero-extended to the widest supported tree (PLRU_MAX_L
//     levels) together with the real level count, so one pair of
//     functions serves every associativity up to 2**PLRU_MAX_L ways.
//
// Tree encoding: heap nodes 1..NUM_WAYS-1 are stored at bit (node-1).
// Node r has children 2r (bit=0) and 2r+1 (bit=1).
package plru_pkg;

  localparam int PLRU_DEF_WAYS  = 4;
  localparam int PLRU_DEF_SETS  = 64;
  localparam int PLRU_DEF_L     = $clog2(PLRU_DEF_WAYS);
  localparam int PLRU_DEF_SET_W = $clog2(PLRU_DEF_SETS);

  // Widest tree the helpers can handle: 8 levels, 256 ways.
  localparam int PLRU_MAX_L     = 8;
  localparam int PLRU_MAX_NODES = (1 << PLRU_MAX_L) - 1;
  localparam int PLRU_LVL_W     = $clog2(PLRU_MAX_L);

  typedef logic [PLRU_MAX_NODES-1:0] plru_tree_t;
  typedef logic [PLRU_MAX_L-1:0]     plru_way_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fsm_state_e;

  // Walk from the root following the stored bits; after lvl steps the
  // node index is NUM_WAYS + way, so the way is its low lvl bits.
  function automatic plru_way_t plru_victim(input plru_tree_t tree,
                                            input int unsigned lvl);
    logic [PLRU_MAX_L:0]   r;
    logic [PLRU_MAX_L-1:0] idx;
    plru_way_t             mask;
    r    = (PLRU_MAX_L+1)'(1);
    mask = plru_way_t'((32'd1 << lvl) - 32'd1);
    for (int unsigned k = 0; k < PLRU_MAX_L; k++) begin
      if (k < lvl) begin
        idx = r[PLRU_MAX_L-1:0] - PLRU_MAX_L'(1);
        r   = {r[PLRU_MAX_L-1:0], tree[idx]};
      end
    end
    return r[PLRU_MAX_L-1:0] & mask;
  endfunction

  // Force every node on the path to way so that it points away from it.
  // Bits are written outright (never toggled); off-path nodes keep
  // their value.
  function automatic plru_tree_t plru_touch(input plru_tree_t tree,
                                            input plru_way_t way,
                                            input int unsigned lvl);
    plru_tree_t            t;
    logic [PLRU_MAX_L:0]   r;
    logic [PLRU_MAX_L-1:0] idx;
    logic [PLRU_LVL_W-1:0] bsel;
    logic                  b;
    t = tree;
    r = (PLRU_MAX_L+1)'(1);
    for (int unsigned k = 0; k < PLRU_MAX_L; k++) begin
      if (k < lvl) begin
        bsel   = PLRU_LVL_W'(lvl - 32'd1 - k);
        b      = way[bsel];
        idx    = r[PLRU_MAX_L-1:0] - PLRU_MAX_L'(1);
        t[idx] = ~b;
        r      = {r[PLRU_MAX_L-1:0], b};
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// plru_tree_logic -- combinational victim selection and access update
// for a single PLRU tree of NUM_WAYS ways.
//
// Ports:
//   tree_in   in  NUM_WAYS-1        current tree (bit n-1 = heap node n)
//   way_in    in  $clog2(NUM_WAYS)  way to mark as most recently used
//   victim    out $clog2(NUM_WAYS)  way the tree currently points at
//   tree_out  out NUM_WAYS-1        tree_in with way_in marked as used
module plru_tree_logic
  import plru_pkg::*;
#(
  parameter int NUM_WAYS = PLRU_DEF_WAYS
) (
  input  logic [NUM_WAYS-2:0]         tree_in,
  input  logic [$clog2(NUM_WAYS)-1:0] way_in,
  output logic [$clog2(NUM_WAYS)-1:0] victim,
  output logic [NUM_WAYS-2:0]         tree_out
);

  localparam int L     = $clog2(NUM_WAYS);
  localparam int NODES = NUM_WAYS - 1;

  plru_tree_t tree_wide;

  // Zero-extend into the generic width; the helpers only look at the
  // first L levels, so the padding never influences the result.
  assign tree_wide = plru_tree_t'(tree_in);
  assign victim    = L'(plru_victim(tree_wide, L));
  assign tree_out  = NODES'(plru_touch(tree_wide, plru_way_t'(way_in), L));

endmodule

// File: rtl/plru_replacement_ctrl.sv
// plru_replacement_ctrl -- owner of the per-set tree-PLRU state of a
// set-associative cache.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   touch_valid/touch_set/touch_way  hit-path access notification
//                                    (accepted only in RUN)
//   vic_req_valid/ready/set/alloc    victim request from the refill side;
//                                    alloc marks the victim as used
//   vic_rsp_valid/ready/set/way      registered victim response
//   flush_req                        one-cycle pulse: clear every tree
//   busy                             high while INIT or FLUSH sweeps run
//
// Operation: INIT (after reset) and FLUSH write an all-zero tree into one
// set per cycle. In RUN a request is answered one cycle after acceptance
// from the tree contents of the accept cycle. Touch and alloc updates to
// the same set in one cycle merge into a single write, alloc applied last.
module plru_replacement_ctrl
  import plru_pkg::*;
#(
  parameter int NUM_WAYS = PLRU_DEF_WAYS,
  parameter int NUM_SETS = PLRU_DEF_SETS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        touch_valid,
  input  logic [$clog2(NUM_SETS)-1:0] touch_set,
  input  logic [$clog2(NUM_WAYS)-1:0] touch_way,
  input  logic                        vic_req_valid,
  output logic                        vic_req_ready,
  input  logic [$clog2(NUM_SETS)-1:0] vic_req_set,
  input  logic                        vic_req_alloc,
  output logic                        vic_rsp_valid,
  input  logic                        vic_rsp_ready,
  output logic [$clog2(NUM_SETS)-1:0] vic_rsp_set,
  output logic [$clog2(NUM_WAYS)-1:0] vic_rsp_way,
  input  logic                        flush_req,
  output logic                        busy
);

  localparam int L     = $clog2(NUM_WAYS);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int NODES = NUM_WAYS - 1;

  // ---------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------
  fsm_state_e       state_reg, state_next;
  logic [SET_W-1:0] ptr_reg, ptr_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [SET_W-1:0] rsp_set_reg, rsp_set_next;
  logic [L-1:0]     rsp_way_reg, rsp_way_next;

  // ---------------------------------------------------------------
  // Tree storage (flop array, intentionally not reset: the INIT sweep
  // clears it)
  // ---------------------------------------------------------------
  logic [NODES-1:0] tree_mem  [NUM_SETS];
  logic [NODES-1:0] tree_next [NUM_SETS];

  logic [NODES-1:0] touch_tree_rd;
  logic [NODES-1:0] vic_tree_rd;
  logic [NODES-1:0] touch_tree_upd;
  logic [NODES-1:0] alloc_base;
  logic [NODES-1:0] alloc_tree_upd;
  logic [L-1:0]     vic_way;
  logic [L-1:0]     touch_victim_unused;
  logic [L-1:0]     alloc_victim_unused;

  logic run_ok;
  logic touch_we;
  logic vic_acc;
  logic alloc_we;
  logic sweep_we;
  logic same_set;

  assign run_ok        = (state_reg == RUN) && !flush_req;
  assign vic_req_ready = run_ok && (!rsp_valid_reg || vic_rsp_ready);
  assign vic_acc       = vic_req_valid && vic_req_ready;
  assign touch_we      = touch_valid && run_ok;
  assign alloc_we      = vic_acc && vic_req_alloc;
  assign sweep_we      = (state_reg != RUN);
  assign same_set      = touch_we && (touch_set == vic_req_set);

  assign touch_tree_rd = tree_mem[touch_set];
  assign vic_tree_rd   = tree_mem[vic_req_set];

  // The response always comes from the tree as stored, before any write
  // that lands at the end of this cycle.
  assign vic_way = L'(plru_victim(plru_tree_t'(vic_tree_rd), L));

  // When touch and alloc hit the same set, the alloc update is layered
  // on top of the touched tree so both land in one write and alloc owns
  // any shared nodes.
  assign alloc_base = same_set ? touch_tree_upd : vic_tree_rd;

  plru_tree_logic #(
    .NUM_WAYS (NUM_WAYS)
  ) u_touch_path (
    .tree_in  (touch_tree_rd),
    .way_in   (touch_way),
    .victim   (touch_victim_unused),
    .tree_out (touch_tree_upd)
  );

  plru_tree_logic #(
    .NUM_WAYS (NUM_WAYS)
  ) u_alloc_path (
    .tree_in  (alloc_base),
    .way_in   (vic_way),
    .victim   (alloc_victim_unused),
    .tree_out (alloc_tree_upd)
  );

  // Per-set write selection. Sweeps only occur outside RUN, where touch
  // and alloc are both disabled, so the priority order below only
  // matters for the alloc-vs-touch case, already merged in alloc_tree_upd.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SETS; gi++) begin : gen_set
      assign tree_next[gi] =
        (sweep_we && (ptr_reg == SET_W'(gi)))      ? '0 :
        (alloc_we && (vic_req_set == SET_W'(gi)))  ? alloc_tree_upd :
        (touch_we && (touch_set == SET_W'(gi)))    ? touch_tree_upd :
                                                     tree_mem[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    tree_mem <= tree_next;
  end

  // ---------------------------------------------------------------
  // FSM and response register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      ptr_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_set_reg   <= '0;
      rsp_way_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_set_reg   <= rsp_set_next;
      rsp_way_reg   <= rsp_way_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_set_next   = rsp_set_reg;
    rsp_way_next   = rsp_way_reg;

    case (state_reg)
      INIT, FLUSH: begin
        // flush_req has no effect here; the sweep just runs to the end.
        if (ptr_reg == SET_W'(NUM_SETS - 1)) begin
          state_next = RUN;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + SET_W'(1);
        end
      end
      RUN: begin
        if (flush_req) begin
          state_next = FLUSH;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = INIT;
        ptr_next   = '0;
      end
    endcase

    // A pending response survives a RUN->FLUSH transition; only the
    // consumer handshake retires it.
    if (vic_acc) begin
      rsp_valid_next = 1'b1;
      rsp_set_next   = vic_req_set;
      rsp_way_next   = vic_way;
    end else if (rsp_valid_reg && vic_rsp_ready) begin
      rsp_valid_next = 1'b0;
    end
  end

  assign vic_rsp_valid = rsp_valid_reg;
  assign vic_rsp_set   = rsp_set_reg;
  assign vic_rsp_way   = rsp_way_reg;
  assign busy          = (state_reg != RUN);

endmodule
